xgriscv_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch stage and the memory stage of the xgriscv pipeline. It arbitrates, issues one transaction at a time with a request/ready handshake, returns read data, and drives the stall signals that gate the PC register and pipeline register enables. Data accesses win by default; a starvation counter guarantees forward progress for fetch.

---
 rtl/xgriscv_mem_arbiter_pkg.sv | 24 ++
 rtl/xgriscv_mem_arbiter_pick.sv | 20 ++
 rtl/xgriscv_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_xgriscv_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgriscv_mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package xgriscv_mem_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int ADDR_SIZE = 32;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  // Reads always fetch the whole word; only stores use the lane pattern.
  function automatic logic [3:0] be_for(input logic we, input logic [3:0] amp);
    return we ? amp : 4'b1111;
  endfunction

endpackage

// File: rtl/xgriscv_mem_arbiter_pick.sv
// Combinational grant decision: data first, fetch once the starvation limit is hit.
module xgriscv_mem_arbiter_pick
  import xgriscv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             i_fetch_cand,
  input  logic             i_data_cand,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_grant_i,
  output logic             o_grant_d
);

  logic w_starved;

  assign w_starved = (i_starve_cnt == CNT_W'(STARVE_MAX));
  assign o_grant_d = i_data_cand & ~(i_fetch_cand & w_starved);
  assign o_grant_i = i_fetch_cand & (~i_data_cand | w_starved);

endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// Unified-memory arbiter between instruction fetch and the data stage.
// One transaction in flight; data has priority, bounded by a starvation counter.
module xgriscv_mem_arbiter
  import xgriscv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic                 i_kill,
  output logic                 i_done,
  output logic [XLEN-1:0]      i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  input  logic [3:0]           d_amp,
  output logic                 d_done,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 m_req,
  output logic                 m_we,
  output logic [ADDR_SIZE-1:0] m_addr,
  output logic [XLEN-1:0]      m_wdata,
  output logic [3:0]           m_be,
  input  logic                 m_ready,
  input  logic                 m_rvalid,
  input  logic [XLEN-1:0]      m_rdata,
  output logic                 stall_if,
  output logic                 stall_mem
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e           r_state, w_state_next;
  arb_owner_e           r_owner, w_owner_next;
  logic                 r_drop, w_drop_next;
  logic [CNT_W-1:0]     r_starve_cnt, w_starve_next;
  logic [ADDR_SIZE-1:0] r_m_addr, w_m_addr_next;
  logic                 r_m_we, w_m_we_next;
  logic [XLEN-1:0]      r_m_wdata, w_m_wdata_next;
  logic [3:0]           r_m_be, w_m_be_next;
  logic                 r_i_done, w_i_done_next;
  logic                 r_d_done, w_d_done_next;
  logic [XLEN-1:0]      r_i_rdata, w_i_rdata_next;
  logic [XLEN-1:0]      r_d_rdata, w_d_rdata_next;

  logic w_idle;
  logic w_i_cand;
  logic w_d_cand;
  logic w_grant_i;
  logic w_grant_d;
  logic w_kill_fetch;
  logic w_unused_addr_bits;

  // Memory is word-addressed; the byte offset only matters to the lane logic upstream.
  assign w_unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign w_idle       = (r_state == ARB_IDLE);
  assign w_i_cand     = w_idle & i_req & ~r_i_done & ~i_kill;
  assign w_d_cand     = w_idle & d_req & ~r_d_done;
  assign w_kill_fetch = (r_owner == ARB_OWN_I) & i_kill;

  xgriscv_mem_arbiter_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .i_fetch_cand(w_i_cand),
    .i_data_cand (w_d_cand),
    .i_starve_cnt(r_starve_cnt),
    .o_grant_i   (w_grant_i),
    .o_grant_d   (w_grant_d)
  );

  always_comb begin
    w_state_next   = r_state;
    w_owner_next   = r_owner;
    w_drop_next    = r_drop;
    w_m_addr_next  = r_m_addr;
    w_m_we_next    = r_m_we;
    w_m_wdata_next = r_m_wdata;
    w_m_be_next    = r_m_be;
    w_i_done_next  = 1'b0;
    w_d_done_next  = 1'b0;
    w_i_rdata_next = r_i_rdata;
    w_d_rdata_next = r_d_rdata;

    case (r_state)
      ARB_IDLE: begin
        if (w_grant_d) begin
          w_state_next   = ARB_ISSUE;
          w_owner_next   = ARB_OWN_D;
          w_m_addr_next  = {d_addr[ADDR_SIZE-1:2], 2'b00};
          w_m_we_next    = d_we;
          w_m_wdata_next = d_wdata;
          w_m_be_next    = be_for(d_we, d_amp);
        end else if (w_grant_i) begin
          w_state_next   = ARB_ISSUE;
          w_owner_next   = ARB_OWN_I;
          w_m_addr_next  = {i_addr[ADDR_SIZE-1:2], 2'b00};
          w_m_we_next    = 1'b0;
          w_m_wdata_next = '0;
          w_m_be_next    = be_for(1'b0, 4'b0000);
        end
      end
      ARB_ISSUE: begin
        if (w_kill_fetch) w_drop_next = 1'b1;
        if (m_ready) w_state_next = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (m_rvalid) begin
          w_state_next = ARB_IDLE;
          w_drop_next  = 1'b0;
          if (r_owner == ARB_OWN_D) begin
            w_d_done_next  = 1'b1;
            w_d_rdata_next = m_rdata;
          end else if (!(r_drop | i_kill)) begin
            // A redirect racing the response still abandons the fetch.
            w_i_done_next  = 1'b1;
            w_i_rdata_next = m_rdata;
          end
        end else if (w_kill_fetch) begin
          w_drop_next = 1'b1;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase

    w_starve_next = r_starve_cnt;
    if (!i_req || w_grant_i) begin
      w_starve_next = '0;
    end else if (w_grant_d && w_i_cand && (r_starve_cnt != STARVE_LIM)) begin
      w_starve_next = r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= ARB_OWN_I;
      r_drop       <= 1'b0;
      r_starve_cnt <= '0;
      r_m_addr     <= '0;
      r_m_we       <= 1'b0;
      r_m_wdata    <= '0;
      r_m_be       <= 4'b0000;
      r_i_done     <= 1'b0;
      r_d_done     <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_drop       <= w_drop_next;
      r_starve_cnt <= w_starve_next;
      r_m_addr     <= w_m_addr_next;
      r_m_we       <= w_m_we_next;
      r_m_wdata    <= w_m_wdata_next;
      r_m_be       <= w_m_be_next;
      r_i_done     <= w_i_done_next;
      r_d_done     <= w_d_done_next;
      r_i_rdata    <= w_i_rdata_next;
      r_d_rdata    <= w_d_rdata_next;
    end
  end

  assign m_req     = (r_state == ARB_ISSUE);
  assign m_we      = r_m_we;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign m_be      = r_m_be;
  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall_if  = i_req & ~r_i_done;
  assign stall_mem = d_req & ~r_d_done;

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level memory model.
module tb_xgriscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_kill;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_amp;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        stall_if;
  logic        stall_mem;

  int checks = 0;
  int errors = 0;

  // Responder memory (written by m_be) and reference memory (written by d_amp at d_done).
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [3:0]  amp_tab [7];

  always #5 clk = ~clk;

  xgriscv_mem_arbiter #(
    .STARVE_MAX(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_kill   (i_kill),
    .i_done   (i_done),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_amp    (d_amp),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .stall_if (stall_if),
    .stall_mem(stall_mem)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 72'(m_req), 72'(1'b1));
  endtask

  // Checks the issued fields, accepts, and answers L cycles later; returns in the done cycle.
  task automatic run_txn(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] rdata, input int lat);
    wait_req(tag);
    chk({tag, "_addr"}, 72'(m_addr), 72'(exp_addr));
    chk({tag, "_ctl"}, 72'({m_we, m_be}), 72'({exp_we, exp_be}));
    if (exp_we) chk({tag, "_wdata"}, 72'(m_wdata), 72'(exp_wdata));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    repeat (lat - 1) tick();
    m_rvalid = 1'b1;
    m_rdata  = rdata;
    tick();
    m_rvalid = 1'b0;
  endtask

  initial begin
    logic        f_pend, d_pend, out_busy, out_we;
    logic [3:0]  out_be, out_idx;
    logic [31:0] out_wdata;
    logic [2:0]  sel;
    int          out_cnt, f_age, d_age, max_age, n_i, n_d;

    amp_tab[0] = 4'b0001; amp_tab[1] = 4'b0010; amp_tab[2] = 4'b0100; amp_tab[3] = 4'b1000;
    amp_tab[4] = 4'b0011; amp_tab[5] = 4'b1100; amp_tab[6] = 4'b1111;

    reset = 1'b0; i_req = 1'b1; i_addr = 32'h0; i_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_amp = 4'h0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    repeat (3) tick();

    // Reset state
    chk("rst_ctl", 72'({m_req, m_we, m_be, i_done, d_done}), 72'(0));
    chk("rst_addr", 72'(m_addr), 72'(0));
    chk("rst_wdata", 72'(m_wdata), 72'(0));
    chk("rst_rdata", 72'({i_rdata, d_rdata}), 72'(0));
    chk("rst_stall", 72'({stall_if, stall_mem}), 72'(2'b10));
    i_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Single fetch, L=2
    i_req = 1'b1; i_addr = 32'h8000_0002;
    tick();
    chk("fetch_cycle1", 72'(m_req), 72'(1'b1));
    run_txn("fetch", 32'h8000_0000, 1'b0, 4'b1111, 32'h0, 32'h0050_0093, 2);
    chk("fetch_done", 72'({i_done, d_done}), 72'(2'b10));
    chk("fetch_rdata", 72'(i_rdata), 72'(32'h0050_0093));
    chk("fetch_stall", 72'(stall_if), 72'(1'b0));
    i_req = 1'b0;
    tick();
    chk("fetch_pulse", 72'({i_done, m_req}), 72'(0));
    chk("fetch_hold", 72'(i_rdata), 72'(32'h0050_0093));

    // Contention: store wins, fetch issues from the d_done cycle
    i_req = 1'b1; i_addr = 32'h8000_0010;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0026; d_wdata = 32'h00AB_0000; d_amp = 4'b0100;
    run_txn("cont_d", 32'h1000_0024, 1'b1, 4'b0100, 32'h00AB_0000, 32'h0, 1);
    chk("cont_d_done", 72'({d_done, i_done, stall_mem, stall_if}), 72'(4'b1001));
    d_req = 1'b0;
    tick();
    chk("cont_i_nodead", 72'({m_req, m_addr}), 72'({1'b1, 32'h8000_0010}));
    run_txn("cont_i", 32'h8000_0010, 1'b0, 4'b1111, 32'h0, 32'h1111_1111, 1);
    chk("cont_i_done", 72'({i_done, i_rdata}), 72'({1'b1, 32'h1111_1111}));
    i_req = 1'b0;
    tick();

    // Starvation, limit 2: a kill in each d_done cycle keeps fetch out of that slot,
    // so fetch and data meet twice and the third meeting goes to fetch: D, D, I, D.
    i_req = 1'b1; i_addr = 32'h8000_0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0048;
    run_txn("stv_d1", 32'h1000_0048, 1'b0, 4'b1111, 32'h0, 32'hD000_0001, 1);
    chk("stv_d1_done", 72'({d_done, d_rdata}), 72'({1'b1, 32'hD000_0001}));
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    chk("stv_kill_gap1", 72'(m_req), 72'(1'b0));
    run_txn("stv_d2", 32'h1000_0048, 1'b0, 4'b1111, 32'h0, 32'hD000_0002, 2);
    chk("stv_d2_done", 72'({d_done, d_rdata}), 72'({1'b1, 32'hD000_0002}));
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    chk("stv_kill_gap2", 72'(m_req), 72'(1'b0));
    run_txn("stv_i", 32'h8000_0040, 1'b0, 4'b1111, 32'h0, 32'h1000_0013, 1);
    chk("stv_i_done", 72'({i_done, i_rdata}), 72'({1'b1, 32'h1000_0013}));
    i_req = 1'b0;
    tick();
    chk("stv_d4_nodead", 72'({m_req, m_addr}), 72'({1'b1, 32'h1000_0048}));
    run_txn("stv_d4", 32'h1000_0048, 1'b0, 4'b1111, 32'h0, 32'hD000_0004, 1);
    chk("stv_d4_done", 72'(d_done), 72'(1'b1));
    d_req = 1'b0;
    tick();

    // Kill during WAIT: response absorbed, no i_done, redirected fetch follows
    i_req = 1'b1; i_addr = 32'h8000_0080;
    wait_req("kill");
    chk("kill_addr", 72'(m_addr), 72'(32'h8000_0080));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    tick();
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    tick();
    m_rvalid = 1'b0;
    chk("kill_no_done", 72'({i_done, stall_if}), 72'(2'b01));
    i_addr = 32'h8000_0084;
    tick();
    chk("kill_next_issue", 72'({m_req, m_addr}), 72'({1'b1, 32'h8000_0084}));
    run_txn("kill_next", 32'h8000_0084, 1'b0, 4'b1111, 32'h0, 32'h1234_5678, 1);
    chk("kill_next_done", 72'({i_done, i_rdata}), 72'({1'b1, 32'h1234_5678}));
    i_req = 1'b0;
    tick();

    // Backpressure: fields stable while m_ready stays low
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_000C; d_wdata = 32'hCAFE_F00D; d_amp = 4'b1111;
    wait_req("bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp_stable", 72'({m_req, m_we, m_be, m_addr, m_wdata}),
          72'({1'b1, 1'b1, 4'b1111, 32'h1000_000C, 32'hCAFE_F00D}));
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    // Reset mid-WAIT, then a stray response
    reset = 1'b0; d_req = 1'b0;
    tick();
    chk("rst2_ctl", 72'({m_req, m_we, m_be, i_done, d_done}), 72'(0));
    chk("rst2_addr", 72'({m_addr, m_wdata}), 72'(0));
    chk("rst2_rdata", 72'({i_rdata, d_rdata}), 72'(0));
    reset = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick();
    m_rvalid = 1'b0;
    chk("stray_ignored", 72'({i_done, d_done, m_req, d_rdata}), 72'(0));
    tick();
    chk("stray_quiet", 72'({i_done, d_done, m_req}), 72'(0));

    // Randomized traffic against the memory models
    for (int k = 0; k < 16; k++) begin
      mem[k]     = $urandom;
      ref_mem[k] = mem[k];
    end
    f_pend = 1'b0; d_pend = 1'b0; out_busy = 1'b0; out_we = 1'b0; out_be = 4'h0;
    out_idx = 4'h0; out_wdata = 32'h0; out_cnt = 0;
    f_age = 0; d_age = 0; max_age = 0; n_i = 0; n_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (i_done === 1'b1) begin
        chk("rnd_i_pend", 72'(f_pend), 72'(1'b1));
        chk("rnd_i_rdata", 72'(i_rdata), 72'(ref_mem[i_addr[5:2]]));
        f_pend = 1'b0; i_req = 1'b0; f_age = 0; n_i++;
      end
      if (d_done === 1'b1) begin
        chk("rnd_d_pend", 72'(d_pend), 72'(1'b1));
        if (d_we) begin
          for (int b = 0; b < 4; b++)
            if (d_amp[b]) ref_mem[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end else begin
          chk("rnd_d_rdata", 72'(d_rdata), 72'(ref_mem[d_addr[5:2]]));
        end
        d_pend = 1'b0; d_req = 1'b0; d_age = 0; n_d++;
      end

      m_rvalid = 1'b0;
      m_ready  = 1'b0;
      if (out_busy) begin
        out_cnt--;
        if (out_cnt == 0) begin
          m_rvalid = 1'b1;
          out_busy = 1'b0;
          if (out_we) begin
            for (int b = 0; b < 4; b++)
              if (out_be[b]) mem[out_idx][8*b +: 8] = out_wdata[8*b +: 8];
            m_rdata = $urandom;
          end else begin
            m_rdata = mem[out_idx];
          end
        end
      end else if (m_req === 1'b1) begin
        m_ready = 1'($urandom_range(1, 0));
        if (m_ready) begin
          if (m_addr[28]) begin
            chk("rnd_d_acc", 72'({d_pend, m_addr, m_we, m_be}),
                72'({1'b1, d_addr[31:2], 2'b00, d_we, (d_we ? d_amp : 4'hF)}));
            if (m_we) chk("rnd_d_wdata", 72'(m_wdata), 72'(d_wdata));
          end else begin
            chk("rnd_i_acc", 72'({f_pend, m_addr, m_we, m_be}),
                72'({1'b1, i_addr[31:2], 2'b00, 1'b0, 4'hF}));
          end
          out_busy  = 1'b1;
          out_we    = m_we;
          out_be    = m_be;
          out_idx   = m_addr[5:2];
          out_wdata = m_wdata;
          out_cnt   = int'($urandom_range(3, 1));
        end
      end

      if (!f_pend && $urandom_range(3, 0) == 0) begin
        f_pend = 1'b1; i_req = 1'b1;
        i_addr = 32'h8000_0000 | ($urandom & 32'h3F);
      end
      if (!d_pend && $urandom_range(2, 0) == 0) begin
        d_pend = 1'b1; d_req = 1'b1;
        d_we    = 1'($urandom_range(1, 0));
        d_addr  = 32'h1000_0000 | ($urandom & 32'h3F);
        d_wdata = $urandom;
        sel     = 3'($urandom_range(6, 0));
        d_amp   = amp_tab[sel];
      end
      if (f_pend) f_age++;
      if (d_pend) d_age++;
      if (f_age > max_age) max_age = f_age;
      if (d_age > max_age) max_age = d_age;
    end
    chk("rnd_wait_bound", 72'(max_age < 150), 72'(1'b1));
    chk("rnd_progress", 72'((n_i > 50) && (n_d > 50)), 72'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
